// File: rtl/mcu_fetch.sv
// Instruction fetch stage: streams 16-bit words from a synchronous
// instruction RAM into a 2-entry {pc,data} buffer that feeds decode.
// A redirect flushes the buffer and refetches from a new address.
//
// Handshake: ins_valid/ins_ready follow strict valid/ready semantics.
// A word moves to decode on a rising edge where ins_valid=1 and
// ins_ready=1. ins_valid, ins_data and ins_pc depend only on registers
// (and reset), never on ins_ready. They stay stable while ins_valid=1
// and ins_ready=0.
module mcu_fetch #(
    parameter logic [11:0] RESET_PC   = 12'h000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] ram_ad,
    output logic        ram_ce,
    output logic        ram_oce,
    output logic        ram_wre,
    input  logic [15:0] ram_dout,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_data,
    output logic [11:0] ins_pc
);

    // Buffer capacity; the entry logic below is written for two slots.
    localparam logic [2:0] LP_DEPTH = 3'(FIFO_DEPTH);

    logic [11:0] r_fetch_pc;   // next address to read
    logic [11:0] r_tag;        // address of the read currently in flight
    logic        r_inflight;   // a RAM read returns this cycle
    logic        r_squash;     // returning word belongs to a flushed stream
    logic [1:0]  r_count;      // buffered entries (0..2)
    logic [11:0] r_pc0;        // slot 0 is always the head
    logic [15:0] r_data0;
    logic [11:0] r_pc1;
    logic [15:0] r_data1;

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occupancy;
    logic        w_wr_slot1;

    assign ram_ad    = r_fetch_pc;
    assign ram_oce   = 1'b1;
    assign ram_wre   = 1'b0;

    assign ins_valid = ~reset & (r_count != 2'd0);
    assign ins_data  = r_data0;
    assign ins_pc    = r_pc0;

    assign w_pop  = ins_valid & ins_ready;
    assign w_push = r_inflight & ~r_squash;

    // Entries that will be owed space after this edge: buffered plus the
    // word in flight, minus the one leaving. A new read is only issued
    // when its data is guaranteed a slot, so the buffer never overflows.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign ram_ce      = ~reset & ~redirect & (w_occupancy < LP_DEPTH);

    // A pushed word lands behind whatever survives this edge's pop.
    assign w_wr_slot1  = (r_count - {1'b0, w_pop}) != 2'd0;

    // Fetch address, in-flight tracking, redirect flush and buffer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_tag      <= 12'h000;
            r_inflight <= 1'b0;
            r_squash   <= 1'b0;
            r_count    <= 2'd0;
            r_pc0      <= 12'h000;
            r_data0    <= 16'h0000;
            r_pc1      <= 12'h000;
            r_data1    <= 16'h0000;
        end else begin
            r_inflight <= ram_ce;
            if (ram_ce) begin
                r_tag      <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 12'd1;
            end

            if (redirect) begin
                // The word returning now belongs to the old stream; any
                // transfer this cycle has already completed for decode.
                r_fetch_pc <= redirect_pc;
                r_count    <= 2'd0;
                r_squash   <= r_inflight;
            end else begin
                r_squash <= 1'b0;
                if (w_pop) begin
                    r_pc0   <= r_pc1;
                    r_data0 <= r_data1;
                end
                // Later assignment wins, so a push into slot 0 overrides
                // the shift above when the buffer drains to empty.
                if (w_push) begin
                    if (w_wr_slot1) begin
                        r_pc1   <= r_tag;
                        r_data1 <= ram_dout;
                    end else begin
                        r_pc0   <= r_tag;
                        r_data0 <= ram_dout;
                    end
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule
